// File: rtl/hamming_sec_decoder_pipe.sv
// Two-stage Hamming(12,8) SEC decoder with valid/ready flow control.
// Define HAMMING_SEC_STATS_EN to build the corrected/uncorrectable statistics registers.
module hamming_sec_decoder_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [3:0]  out_syndrome,
  output logic        out_corrected,
  output logic        out_uncorrectable,
  input  logic        clr_stats,
  output logic [15:0] corr_count,
  output logic [15:0] uncorr_count,
  output logic [3:0]  last_err_syndrome
);

  logic        s1_valid;
  logic [11:0] s1_code;
  logic [3:0]  s1_syndrome;
  logic        s1_adv;
  logic        s2_adv;
  logic [3:0]  syndrome;
  logic [11:0] fixed_code;
  logic        is_corr;
  logic        is_uncorr;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Syndrome is the XOR of the 1-based positions of every set bit.
  always_comb begin
    syndrome = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (in_code[i]) syndrome = syndrome ^ 4'(i + 1);
    end
  end

  always_comb begin
    fixed_code = s1_code;
    for (int i = 0; i < 12; i++) begin
      if (s1_syndrome == 4'(i + 1)) fixed_code[i] = ~s1_code[i];
    end
  end

  assign is_corr   = (s1_syndrome != 4'd0) && (s1_syndrome <= 4'd12);
  assign is_uncorr = (s1_syndrome >= 4'd13);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_code     <= 12'd0;
      s1_syndrome <= 4'd0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code     <= in_code;
        s1_syndrome <= syndrome;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_data          <= 8'd0;
      out_syndrome      <= 4'd0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data          <= {fixed_code[11:8], fixed_code[6:4], fixed_code[2]};
        out_syndrome      <= s1_syndrome;
        out_corrected     <= is_corr;
        out_uncorrectable <= is_uncorr;
      end
    end
  end

`ifdef HAMMING_SEC_STATS_EN
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  // A clear wins over any event transferring in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      corr_count        <= 16'd0;
      uncorr_count      <= 16'd0;
      last_err_syndrome <= 4'd0;
    end else if (out_xfer) begin
      if (out_corrected && corr_count != 16'hFFFF)
        corr_count <= corr_count + 16'd1;
      if (out_uncorrectable && uncorr_count != 16'hFFFF)
        uncorr_count <= uncorr_count + 16'd1;
      if (out_syndrome != 4'd0)
        last_err_syndrome <= out_syndrome;
    end
  end
`else
  logic unused_clr_stats;
  assign unused_clr_stats  = clr_stats;
  assign corr_count        = 16'd0;
  assign uncorr_count      = 16'd0;
  assign last_err_syndrome = 4'd0;
`endif

endmodule
